// File: rtl/rc5_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rc5_pkg
//  Description : Shared types and constants for the RC5-16 key schedule.
//                word_t is the 16-bit RC5 word, P16/Q16 are the RC5 magic
//                constants for w=16, state_t encodes the expansion sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rc5_pkg;

    typedef logic [15:0] word_t;

    localparam word_t P16         = 16'hB7E1;
    localparam word_t Q16         = 16'h9E37;
    localparam int    MAX_ROUNDS  = 16;
    localparam int    NUM_SUBKEYS = 2 * (MAX_ROUNDS + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        MIX     = 3'd2,
        ZEROIZE = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rotl.sv
`default_nettype none
// ============================================================================
//  Module      : rotl
//  Description : Combinational left rotate of a WIDTH-bit word. Only the low
//                log2(WIDTH) bits of the amount matter (rotation is mod WIDTH).
//  Ports       : data_i  - word to rotate
//                n_i     - rotate amount (upper bits ignored)
//                data_o  - rotated word
//  Revision    : 1.0 - initial release
// ============================================================================
module rotl #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] n_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int SH_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] w_dbl;
    logic               w_unused_n;

    // Shifting a doubled copy keeps the wrapped bits without a second shifter.
    assign w_dbl      = {data_i, data_i} << n_i[SH_W-1:0];
    assign data_o     = w_dbl[2*WIDTH-1:WIDTH];
    assign w_unused_n = ^n_i[WIDTH-1:SH_W];

endmodule
`default_nettype wire

// File: rtl/rc5_key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : rc5_key_expand
//  Description : RC5-16 key schedule engine. Expands a key of up to KEY_BYTES
//                bytes into the 34-entry subkey table S, one step per cycle:
//                INIT (t cycles) fills S with the P16/Q16 progression, MIX
//                (3*max(t,c) cycles) folds the key words L into S.
//                Build option RC5_KEY_ZEROIZE_EN adds a ZEROIZE cycle that
//                wipes L, A and B before DONE.
//  Ports       : clk, rst (synchronous, active-low)
//                start      - begin expansion (sampled only in IDLE)
//                key        - key bytes, byte k = key[8k+7:8k]
//                key_len    - key length in bytes (saturates at KEY_BYTES)
//                num_rounds - round count r (saturates at 16)
//                subkeys    - S[k] = subkeys[16k+15:16k]
//                busy       - expansion in progress
//                done       - one-cycle completion pulse
//                valid      - subkeys coherent for last accepted config
//  Revision    : 1.0 - initial release
// ============================================================================
module rc5_key_expand
    import rc5_pkg::*;
#(
    parameter int KEY_BYTES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [8*KEY_BYTES-1:0]        key,
    input  logic [$clog2(KEY_BYTES+1)-1:0] key_len,
    input  logic [4:0]                    num_rounds,
    output logic [16*NUM_SUBKEYS-1:0]     subkeys,
    output logic                          busy,
    output logic                          done,
    output logic                          valid
);

    localparam int C_MAX = KEY_BYTES / 2;
    localparam int KL_W  = $clog2(KEY_BYTES + 1);
    localparam int C_W   = $clog2(C_MAX + 1);
    localparam int J_W   = (C_MAX > 1) ? $clog2(C_MAX) : 1;
    localparam int I_W   = 6;
    localparam int CNT_W = 7;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    word_t           s_q [0:NUM_SUBKEYS-1];
    word_t           s_d [0:NUM_SUBKEYS-1];
    word_t           l_q [0:C_MAX-1];
    word_t           l_d [0:C_MAX-1];
    word_t           a_q, a_d;
    word_t           b_q, b_d;
    logic [I_W-1:0]  i_q, i_d;
    logic [J_W-1:0]  j_q, j_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [I_W-1:0]  t_q, t_d;
    logic [C_W-1:0]  c_q, c_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            valid_q, valid_d;

    // ------------------------------------------------------------------
    // Configuration derived from the inputs, latched on the accepting edge
    // ------------------------------------------------------------------
    logic [4:0]      w_rounds;
    logic [I_W-1:0]  w_t;
    logic [KL_W-1:0] w_klen;
    logic [KL_W:0]   w_klen_p1;
    logic [KL_W:0]   w_half;
    logic [C_W-1:0]  w_c;
    logic [I_W-1:0]  w_max;
    logic [CNT_W-1:0] w_n;
    word_t           w_key_l [0:C_MAX-1];

    always_comb begin
        w_rounds  = (num_rounds > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : num_rounds;
        w_t       = ({1'b0, w_rounds} + 6'd1) << 1;
        w_klen    = (key_len > KL_W'(KEY_BYTES)) ? KL_W'(KEY_BYTES) : key_len;
        w_klen_p1 = {1'b0, w_klen} + (KL_W+1)'(1);
        w_half    = w_klen_p1 >> 1;
        w_c       = C_W'(w_half);
        // An empty key still has one (all-zero) key word.
        if (w_c == '0) begin
            w_c = C_W'(1);
        end
        w_max = (w_t >= I_W'(w_c)) ? w_t : I_W'(w_c);
        w_n   = ({1'b0, w_max} << 1) + {1'b0, w_max};
    end

    // Little-endian key words with bytes beyond the key length forced to 0.
    always_comb begin
        for (int m = 0; m < C_MAX; m++) begin
            w_key_l[m][7:0]  = (KL_W'(2*m)   < w_klen) ? key[16*m +: 8]     : 8'h00;
            w_key_l[m][15:8] = (KL_W'(2*m+1) < w_klen) ? key[16*m+8 +: 8]   : 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // Mixing datapath
    // ------------------------------------------------------------------
    word_t w_sum_a, w_a_new;
    word_t w_sum_b, w_amt_b, w_b_new;

    assign w_sum_a = s_q[i_q] + a_q + b_q;

    rotl #(.WIDTH(16)) u_rotl_a (
        .data_i (w_sum_a),
        .n_i    (16'd3),
        .data_o (w_a_new)
    );

    assign w_sum_b = l_q[j_q] + w_a_new + b_q;
    assign w_amt_b = w_a_new + b_q;

    rotl #(.WIDTH(16)) u_rotl_b (
        .data_i (w_sum_b),
        .n_i    (w_amt_b),
        .data_o (w_b_new)
    );

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        l_d     = l_q;
        a_d     = a_q;
        b_d     = b_q;
        i_d     = i_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        c_d     = c_q;
        n_d     = n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    t_d     = w_t;
                    c_d     = w_c;
                    n_d     = w_n;
                    l_d     = w_key_l;
                    for (int k = 0; k < NUM_SUBKEYS; k++) begin
                        s_d[k] = '0;
                    end
                    a_d     = '0;
                    b_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = INIT;
                end
            end

            INIT: begin
                if (i_q == '0) begin
                    s_d[0] = P16;
                end else begin
                    s_d[i_q] = s_q[i_q - 6'd1] + Q16;
                end
                if (i_q == t_q - 6'd1) begin
                    i_d     = '0;
                    j_d     = '0;
                    a_d     = '0;
                    b_d     = '0;
                    cnt_d   = '0;
                    state_d = MIX;
                end else begin
                    i_d = i_q + 6'd1;
                end
            end

            MIX: begin
                s_d[i_q] = w_a_new;
                l_d[j_q] = w_b_new;
                a_d      = w_a_new;
                b_d      = w_b_new;
                i_d      = ((i_q + 6'd1) == t_q) ? '0 : i_q + 6'd1;
                j_d      = ((C_W'(j_q) + C_W'(1)) == c_q) ? '0 : j_q + J_W'(1);
                cnt_d    = cnt_q + 7'd1;
                if (cnt_q == n_q - 7'd1) begin
`ifdef RC5_KEY_ZEROIZE_EN
                    state_d = ZEROIZE;
`else
                    state_d = DONE;
`endif
                end
            end

`ifdef RC5_KEY_ZEROIZE_EN
            ZEROIZE: begin
                for (int m = 0; m < C_MAX; m++) begin
                    l_d[m] = '0;
                end
                a_d     = '0;
                b_d     = '0;
                state_d = DONE;
            end
`endif

            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                valid_d = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            for (int k = 0; k < NUM_SUBKEYS; k++) begin
                s_q[k] <= '0;
            end
            for (int m = 0; m < C_MAX; m++) begin
                l_q[m] <= '0;
            end
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            t_q     <= '0;
            c_q     <= '0;
            n_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            l_q     <= l_d;
            a_q     <= a_d;
            b_q     <= b_d;
            i_q     <= i_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            t_q     <= t_d;
            c_q     <= c_d;
            n_q     <= n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    genvar gk;
    generate
        for (gk = 0; gk < NUM_SUBKEYS; gk++) begin : g_subkeys
            assign subkeys[16*gk +: 16] = s_q[gk];
        end
    endgenerate

    assign busy  = busy_q;
    assign done  = done_q;
    assign valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rc5_key_expand.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rc5_key_expand
//  Description : Self-checking bench for rc5_key_expand. A behavioural RC5-16
//                key schedule and RC5 encrypt/decrypt provide expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rc5_key_expand;

`ifdef RC5_KEY_ZEROIZE_EN
    localparam int ZX = 1;
`else
    localparam int ZX = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key = '0;
    logic [4:0]   key_len = '0;
    logic [4:0]   num_rounds = '0;
    logic [543:0] subkeys;
    logic         busy, done, valid;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_s   [34];
    logic [15:0] dut_s [34];
    int          m_lat;
    int          m_r;

    rc5_key_expand #(.KEY_BYTES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key        (key),
        .key_len    (key_len),
        .num_rounds (num_rounds),
        .subkeys    (subkeys),
        .busy       (busy),
        .done       (done),
        .valid      (valid)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [15:0] rol16(input logic [15:0] x, input int s);
        int sh;
        sh = s & 15;
        return 16'((32'(x) << sh) | (32'(x) >> (16 - sh)));
    endfunction

    function automatic logic [15:0] ror16(input logic [15:0] x, input int s);
        return rol16(x, 16 - (s & 15));
    endfunction

    task automatic model_expand(input logic [127:0] k, input int klen, input int nr);
        int r, t, kl, c, n, i, j;
        logic [7:0]  kb [16];
        logic [15:0] L  [8];
        logic [15:0] A, B;
        r  = (nr > 16) ? 16 : nr;
        t  = 2 * (r + 1);
        kl = (klen > 16) ? 16 : klen;
        c  = (kl + 1) / 2;
        if (c == 0) c = 1;
        n  = 3 * ((t > c) ? t : c);
        for (int b = 0; b < 16; b++) kb[b] = (b < kl) ? k[8*b +: 8] : 8'h00;
        for (int m = 0; m < 8; m++) L[m] = {kb[2*m+1], kb[2*m]};
        for (int q = 0; q < 34; q++) m_s[q] = 16'h0000;
        m_s[0] = 16'hB7E1;
        for (int q = 1; q < t; q++) m_s[q] = m_s[q-1] + 16'h9E37;
        A = 0; B = 0; i = 0; j = 0;
        for (int q = 0; q < n; q++) begin
            A      = rol16(m_s[i] + A + B, 3);
            m_s[i] = A;
            B      = rol16(L[j] + A + B, int'(A + B));
            L[j]   = B;
            i      = (i + 1) % t;
            j      = (j + 1) % c;
        end
        m_lat = t + n + 1 + ZX;
        m_r   = r;
    endtask

    task automatic rc5_enc(input logic [31:0] pt, input bit use_dut, input int r,
                           output logic [31:0] ct);
        logic [15:0] S [34];
        logic [15:0] A, B;
        for (int q = 0; q < 34; q++) S[q] = use_dut ? dut_s[q] : m_s[q];
        A = pt[15:0] + S[0];
        B = pt[31:16] + S[1];
        for (int i = 1; i <= r; i++) begin
            A = rol16(A ^ B, int'(B)) + S[2*i];
            B = rol16(B ^ A, int'(A)) + S[2*i+1];
        end
        ct = {B, A};
    endtask

    task automatic rc5_dec(input logic [31:0] ct, input bit use_dut, input int r,
                           output logic [31:0] pt);
        logic [15:0] S [34];
        logic [15:0] A, B;
        for (int q = 0; q < 34; q++) S[q] = use_dut ? dut_s[q] : m_s[q];
        A = ct[15:0];
        B = ct[31:16];
        for (int i = r; i >= 1; i--) begin
            B = ror16(B - S[2*i+1], int'(A)) ^ A;
            A = ror16(A - S[2*i], int'(B)) ^ B;
        end
        B = B - S[1];
        A = A - S[0];
        pt = {B, A};
    endtask

    // ---------------- drivers ----------------
    task automatic start_exp(input logic [127:0] k, input int klen, input int nr);
        @(negedge clk);
        key        = k;
        key_len    = 5'(klen);
        num_rounds = 5'(nr);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Cycles from the accepting edge to the first done; -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int q = 1; q <= 400; q++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                cyc = q;
                break;
            end
        end
    endtask

    task automatic capture_dut();
        for (int q = 0; q < 34; q++) dut_s[q] = subkeys[16*q +: 16];
    endtask

    function automatic int first_diff();
        for (int q = 0; q < 34; q++) if (dut_s[q] !== m_s[q]) return q;
        return -1;
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++; if (subkeys !== '0) begin bad++; $display("FAIL reset_subkeys: got nonzero want 0"); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_full_key();
        logic [127:0] k;
        int cyc, d;
        k = rand_key();
        model_expand(k, 16, 12);
        start_exp(k, 16, 12);
        total++; if (busy !== 1'b1)  begin bad++; $display("FAIL full_busy: got %b want 1", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL full_valid_low: got %b want 0", valid); end
        wait_done(cyc);
        total++; if (cyc !== 105 + ZX) begin bad++; $display("FAIL full_latency: got %0d want %0d", cyc, 105 + ZX); end
        capture_dut();
        d = first_diff();
        total++; if (d !== -1) begin bad++; $display("FAIL full_table: S[%0d] got %h want %h", d, dut_s[d], m_s[d]); end
        total++; if (subkeys[543:416] !== '0) begin bad++; $display("FAIL full_tail: got %h want 0", subkeys[543:416]); end
        total++; if (valid !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL full_flags: got valid=%b busy=%b want 1/0", valid, busy); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL full_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_zero_key();
        int cyc, d;
        model_expand(rand_key(), 0, 0);
        start_exp(rand_key(), 0, 0);
        wait_done(cyc);
        total++; if (cyc !== 9 + ZX) begin bad++; $display("FAIL zero_latency: got %0d want %0d", cyc, 9 + ZX); end
        capture_dut();
        d = first_diff();
        total++; if (d !== -1) begin bad++; $display("FAIL zero_table: S[%0d] got %h want %h", d, dut_s[d], m_s[d]); end
    endtask

    task automatic test_saturate();
        logic [127:0] k;
        int cyc, d;
        k = rand_key();
        k[31:24] = 8'hA5;
        model_expand(k, 3, 31);
        start_exp(k, 3, 31);
        wait_done(cyc);
        total++; if (cyc !== m_lat) begin bad++; $display("FAIL sat_rounds_latency: got %0d want %0d", cyc, m_lat); end
        capture_dut();
        d = first_diff();
        total++; if (d !== -1) begin bad++; $display("FAIL sat_rounds_table: S[%0d] got %h want %h", d, dut_s[d], m_s[d]); end
        k = rand_key();
        model_expand(k, 27, 20);
        start_exp(k, 27, 20);
        wait_done(cyc);
        capture_dut();
        d = first_diff();
        total++; if (d !== -1) begin bad++; $display("FAIL sat_keylen_table: S[%0d] got %h want %h", d, dut_s[d], m_s[d]); end
    endtask

    task automatic test_double_start();
        logic [127:0] k;
        int cyc, d, extra;
        k = rand_key();
        model_expand(k, 10, 7);
        start_exp(k, 10, 7);
        cyc = -1;
        for (int q = 1; q <= 400; q++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin cyc = q; break; end
            @(negedge clk);
            start = (q == 2 || q == 9);
            if (q == 2) key = rand_key();
        end
        start = 1'b0;
        total++; if (cyc !== m_lat) begin bad++; $display("FAIL dbl_latency: got %0d want %0d", cyc, m_lat); end
        capture_dut();
        d = first_diff();
        total++; if (d !== -1) begin bad++; $display("FAIL dbl_table: S[%0d] got %h want %h", d, dut_s[d], m_s[d]); end
        extra = 0;
        repeat (150) begin @(posedge clk); #1; if (done === 1'b1) extra++; end
        total++; if (extra !== 0) begin bad++; $display("FAIL dbl_extra_done: got %0d want 0", extra); end
    endtask

    task automatic test_reset_mid_mix();
        int seen;
        // r=4, key 16 bytes: t=10 so cycle 20 falls inside MIX.
        start_exp(rand_key(), 16, 4);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL rst_mid_flags: got busy=%b valid=%b want 0/0", busy, valid); end
        total++; if (subkeys !== '0) begin bad++; $display("FAIL rst_mid_subkeys: got nonzero want 0"); end
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        repeat (150) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_mid_done: got %0d pulses want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k;
        int cyc, d;
        start_exp(rand_key(), 8, 5);
        wait_done(cyc);
        // Start again in the very cycle valid/done are high.
        k          = rand_key();
        key        = k;
        key_len    = 5'd6;
        num_rounds = 5'd9;
        start      = 1'b1;
        model_expand(k, 6, 9);
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got valid=%b busy=%b want 0/1", valid, busy); end
        wait_done(cyc);
        total++; if (cyc !== m_lat) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", cyc, m_lat); end
        capture_dut();
        d = first_diff();
        total++; if (d !== -1) begin bad++; $display("FAIL b2b_table: S[%0d] got %h want %h", d, dut_s[d], m_s[d]); end
    endtask

    task automatic test_random();
        logic [127:0] k;
        int cyc, d, kl, nr;
        for (int it = 0; it < 5; it++) begin
            k  = rand_key();
            kl = $urandom_range(0, 31);
            nr = $urandom_range(0, 31);
            model_expand(k, kl, nr);
            start_exp(k, kl, nr);
            wait_done(cyc);
            total++; if (cyc !== m_lat) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, cyc, m_lat); end
            capture_dut();
            d = first_diff();
            total++; if (d !== -1) begin bad++; $display("FAIL rand_table[%0d]: S[%0d] got %h want %h", it, d, dut_s[d], m_s[d]); end
        end
    endtask

    task automatic test_roundtrip();
        logic [127:0] k;
        logic [31:0]  ct_dut, ct_ref, pt_back;
        int cyc;
        k = rand_key();
        model_expand(k, 16, 12);
        start_exp(k, 16, 12);
        wait_done(cyc);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL rt_valid: got %b want 1", valid); end
        capture_dut();
        rc5_enc(32'h01234567, 1'b1, m_r, ct_dut);
        rc5_enc(32'h01234567, 1'b0, m_r, ct_ref);
        total++; if (ct_dut !== ct_ref) begin bad++; $display("FAIL rt_cipher: got %h want %h", ct_dut, ct_ref); end
        rc5_dec(ct_dut, 1'b1, m_r, pt_back);
        total++; if (pt_back !== 32'h01234567) begin bad++; $display("FAIL rt_plain: got %h want 01234567", pt_back); end
    endtask

    initial begin
        test_reset();
        test_full_key();
        test_zero_key();
        test_saturate();
        test_double_start();
        test_reset_mid_mix();
        test_back_to_back();
        test_random();
        test_roundtrip();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rc5_key_expand.md
Name: rc5_key_expand

Overview:
- RC5-16 key schedule engine: expands a secret key of up to KEY_BYTES bytes into the subkey table S[0:33] (16-bit words) consumed by the encrypt/decrypt round engine.
- Sits directly upstream of the round engine; its subkeys output wires straight to the engine's subkeys input.
- Runs once per key/round-count change, one mixing step per cycle.

Parameters:
- KEY_BYTES, 16, maximum key length in bytes (even, 2..32); c_max = KEY_BYTES/2 key words.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  begin expansion; sampled only in IDLE.
- key  in  8*KEY_BYTES  key bytes, byte k = key[8k+7:8k].
- key_len  in  $clog2(KEY_BYTES+1)  key length in bytes, 0..KEY_BYTES.
- num_rounds  in  5  rounds r the table is built for.
- subkeys  out  16 x [0:33]  expanded table S.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse when the table is complete.
- valid  out  1  level; subkeys are coherent for the last accepted configuration.

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; subkeys all 0; busy=0, done=0, valid=0; L, A, B, i, j and counters cleared. Reset in any state aborts the expansion immediately.
- Derived values, latched on the accepting edge:
  - r' = min(num_rounds,16) (values above 16 saturate).
  - t = 2(r'+1).
  - c = max(1, ceil(key_len/2)); key_len above KEY_BYTES saturates.
  - n = 3*max(t,c).
- Key load, on the same edge:
  - L[m] = {byte 2m+1, byte 2m}, little-endian.
  - Bytes at index >= key_len are forced to 0.
  - All S[0:33] cleared; valid dropped; busy raised.
- start while busy is ignored.
- INIT, t cycles: S[0]=P16=16'hB7E1, then S[k]=S[k-1]+Q16 (Q16=16'h9E37) mod 2^16, one entry per cycle. Entries k>=t stay 0.
- MIX, n cycles: A=B=i=j=0 at entry. Each cycle:
  - A' = rotl(S[i]+A+B, 3); S[i] = A'.
  - B' = rotl(L[j]+A'+B, (A'+B)[3:0]); L[j] = B'.
  - i = (i+1 == t) ? 0 : i+1; j = (j+1 == c) ? 0 : j+1.
  - All additions are 16-bit wrapping.
- DONE, 1 cycle: done=1, busy=0, valid=1, then IDLE.
- Latency: done is high exactly t+n+1 cycles after the accepting edge.
- subkeys may change every cycle while busy; consumers use them only when valid==1.
- valid stays high until the next accepted start or reset.
- start accepted in the same cycle valid is high: valid drops on that edge.

Optional Feature:
- Macro: RC5_KEY_ZEROIZE_EN.
- Defined: an extra ZEROIZE state between MIX and DONE clears L, the internal key copy, A and B in one cycle. Latency becomes t+n+2.
- Undefined: no ZEROIZE state; L, A and B keep their final values until the next start or reset.

Decomposition:
- Package rc5_pkg holds:
  - word_t (16-bit logic).
  - P16 and Q16.
  - MAX_ROUNDS=16 and NUM_SUBKEYS=34.
  - State enum: IDLE, INIT, MIX, ZEROIZE, DONE.
- Both rotations reuse the existing rotl module (data_i, n_i, data_o): one instance with n_i=16'd3, one with n_i=A'+B.
- No new sub-module.

Test Plan:
- Reset mid-MIX (assert rst at cycle 20 after start) -> next cycle state IDLE, subkeys all 0, busy=0, valid=0, done never pulses.
- key_len=16, num_rounds=12 (t=26, c=8, n=78) -> done exactly 105 cycles after accept (106 with RC5_KEY_ZEROIZE_EN); S[0:25] match the software model; S[26:33]=0.
- key_len=0, num_rounds=0 (t=2, c=1, n=6) -> done after 9 cycles; S matches the model with L[0]=0; S[2:33]=0.
- num_rounds=31 -> treated as 16: t=34, all 34 entries nonzero-model-checked; key_len=3 -> byte 3 forced 0, c=2.
- Pulse start twice while busy -> second ignored; only one done; timing identical to a single start.
- End-to-end with the round engine: 16-byte key, r=12, encrypt 32'h01234567 then decrypt the result -> returns 32'h01234567; both transactions start only after valid=1.
